ca_engine: RTL and testbench
============================

Name: ca_engine

Overview:
- Parametrised elementary (radius-1, 8-entry rule table) cellular-automaton engine.
- Holds a WIDTH-cell state register and advances it one generation per clock, either as a single step or as a free run of N generations.
- Supports wrap-around or fixed-zero boundaries, early stop on a stable pattern, and a generation counter.
- Sits between the seed/rule control logic and the display/readout path.

Parameters:
- WIDTH, 8, number of cells; legal values are 3 and above.
- GEN_W, 16, width of the generation limit and generation counter.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- load  in  1  pulse; copy seed into the state register.
- seed  in  WIDTH  initial pattern.
- rule  in  8  Wolfram rule; bit index is {left, centre, right}.
- bnd_zero  in  1  0 = wrap-around boundary, 1 = cells outside the array read 0.
- step  in  1  pulse; advance exactly one generation (IDLE only).
- start  in  1  pulse; run gen_limit generations.
- gen_limit  in  GEN_W  number of generations for a run.
- stop_stable  in  1  end a run early when a generation leaves the state unchanged.
- halt  in  1  abort a run.
- state  out  WIDTH  current cell pattern.
- gen_count  out  GEN_W  generations applied since the last load or start.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a run ends (limit reached, stable stop, or zero limit).
- stable  out  1  last applied generation left the state unchanged.

Behaviour:
- Reset (async, resetn low):
  - state = 0, gen_count = 0, FSM = IDLE.
  - busy = 0, done = 0, stable = 0.
  - Latched rule and boundary = 0.
- Next-state function for cell i:
  - next[i] = R[{L, state[i], Rn}].
  - L = state[i+1]; Rn = state[i-1].
  - Wrap mode: index WIDTH wraps to 0 and index -1 wraps to WIDTH-1.
  - bnd_zero mode: those out-of-range neighbours read 0.
  - R and the boundary mode are the live inputs for step; for a run they are the values latched at start.
- Input priority in any state: load > halt > start > step.
  - Lower-priority inputs asserted in the same cycle are ignored.
- load:
  - state <= seed, gen_count <= 0, stable <= 0, FSM -> IDLE.
  - Aborts a run without a done pulse.
- IDLE:
  - step: state <= next, gen_count += 1, stable <= (next == state). Single-cycle latency; FSM stays IDLE.
  - start with gen_limit == 0: done pulses next cycle; state unchanged; gen_count <= 0; FSM stays IDLE.
  - start with gen_limit > 0: latch rule, bnd_zero, stop_stable and gen_limit; gen_count <= 0; FSM -> RUN. No generation is applied in the start cycle.
- RUN (busy = 1), each cycle:
  - state <= next, gen_count += 1, stable <= (next == state).
  - If gen_count+1 == limit, or (stop_stable and next == state): FSM -> IDLE with done = 1 in the following cycle.
  - Only one done pulse is produced even if both end conditions coincide.
  - halt: FSM -> IDLE immediately, state and gen_count hold, no done pulse.
  - start and step are ignored while in RUN.
  - Input changes to rule, bnd_zero or gen_limit have no effect until the next start.
- gen_count wraps modulo 2^GEN_W during step-only use. During a run it never exceeds the limit.
- Reset asserted mid-run returns everything to reset values immediately; done is not pulsed.

Test Plan:
- WIDTH=8, rule 0x5A, wrap, load seed 0x10, start with gen_limit=4 -> state sequence 0x28, 0x44, 0xAA, 0x00. done pulses once, gen_count=4, stable=0.
- Same seed and rule, gen_limit=10, stop_stable=1 -> state reaches 0x00 at gen 4, gen 5 is stable, run ends with gen_count=5, stable=1, single done pulse.
- Rule 0xAA (shift toward higher index), seed 0x80, one step with wrap -> 0x01; reload, one step with bnd_zero=1 -> 0x00. Rule 0x5A, seed 0x01: wrap gives 0x82, zero boundary gives 0x02.
- start with gen_limit=0 -> done pulses once, busy never asserts, state unchanged.
- Run with gen_limit=100, halt after 3 generations -> busy drops, gen_count=3, no done pulse. load asserted together with start -> seed loaded, FSM stays IDLE.
- resetn pulsed low mid-run (asynchronously, between clock edges) -> state=0, busy=0, gen_count=0 immediately. Rule 0xCC (identity) step -> stable=1.

Source files
------------

// File: rtl/ca_engine_if.sv
// ca_engine control/readout bundle.
// master drives load/seed/rule/run controls; slave returns state, gen_count, busy, done, stable.
interface ca_engine_if #(
  parameter int WIDTH = 8,
  parameter int GEN_W = 16
);
  logic             load;
  logic [WIDTH-1:0] seed;
  logic [7:0]       rule;
  logic             bnd_zero;
  logic             step;
  logic             start;
  logic [GEN_W-1:0] gen_limit;
  logic             stop_stable;
  logic             halt;
  logic [WIDTH-1:0] state;
  logic [GEN_W-1:0] gen_count;
  logic             busy;
  logic             done;
  logic             stable;

  modport master (
    output load, seed, rule, bnd_zero, step, start,
    output gen_limit, stop_stable, halt,
    input  state, gen_count, busy, done, stable
  );

  modport slave (
    input  load, seed, rule, bnd_zero, step, start,
    input  gen_limit, stop_stable, halt,
    output state, gen_count, busy, done, stable
  );
endinterface

// File: rtl/ca_engine.sv
// Elementary (radius-1) cellular automaton engine with single step and counted runs.
// Ports: clk, resetn (async active-low), bus (ca_engine_if.slave: controls in, state/status out).
module ca_engine #(
  parameter int WIDTH = 8,
  parameter int GEN_W = 16
) (
  input  logic        clk,
  input  logic        resetn,
  ca_engine_if.slave  bus
);

  typedef enum logic {IDLE, RUN} st_t;

  st_t              st_q;
  logic [WIDTH-1:0] state_q;
  logic [GEN_W-1:0] gen_q;
  logic [GEN_W-1:0] lim_q;
  logic [7:0]       rule_q;
  logic             bz_q;
  logic             ss_q;
  logic             busy_q;
  logic             done_q;
  logic             stable_q;

  logic [WIDTH-1:0] nxt_step;
  logic [WIDTH-1:0] nxt_run;
  logic [GEN_W-1:0] gen_inc;
  logic             run_same;
  logic             run_end;

  // ext = {left of MSB, cells, right of LSB}; ext[i +: 3] is {L, C, R} of cell i.
  function automatic logic [WIDTH-1:0] evolve(
    input logic [WIDTH-1:0] s,
    input logic [7:0]       r,
    input logic             bz
  );
    logic [WIDTH+1:0] ext;
    logic [WIDTH-1:0] n;
    ext = {(bz ? 1'b0 : s[0]), s, (bz ? 1'b0 : s[WIDTH-1])};
    for (int i = 0; i < WIDTH; i++) begin
      n[i] = r[ext[i +: 3]];
    end
    return n;
  endfunction

  always_comb begin
    nxt_step = evolve(state_q, bus.rule, bus.bnd_zero);
    nxt_run  = evolve(state_q, rule_q, bz_q);
    gen_inc  = gen_q + 1'b1;
    run_same = (nxt_run == state_q);
    run_end  = (gen_inc == lim_q) || (ss_q && run_same);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q     <= IDLE;
      state_q  <= '0;
      gen_q    <= '0;
      lim_q    <= '0;
      rule_q   <= '0;
      bz_q     <= 1'b0;
      ss_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        state_q  <= bus.seed;
        gen_q    <= '0;
        stable_q <= 1'b0;
        st_q     <= IDLE;
        busy_q   <= 1'b0;
      end else if (bus.halt) begin
        st_q   <= IDLE;
        busy_q <= 1'b0;
      end else if (st_q == RUN) begin
        state_q  <= nxt_run;
        gen_q    <= gen_inc;
        stable_q <= run_same;
        if (run_end) begin
          st_q   <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end else if (bus.start) begin
        gen_q <= '0;
        if (bus.gen_limit == '0) begin
          done_q <= 1'b1;
        end else begin
          lim_q  <= bus.gen_limit;
          rule_q <= bus.rule;
          bz_q   <= bus.bnd_zero;
          ss_q   <= bus.stop_stable;
          st_q   <= RUN;
          busy_q <= 1'b1;
        end
      end else if (bus.step) begin
        state_q  <= nxt_step;
        gen_q    <= gen_q + 1'b1;
        stable_q <= (nxt_step == state_q);
      end
    end
  end

  assign bus.state     = state_q;
  assign bus.gen_count = gen_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stable    = stable_q;

endmodule

// File: tb/tb_ca_engine.sv
// Self-checking bench for ca_engine.
// Table-driven single steps, directed run/halt/reset sequences, randomized runs vs a model.
module tb_ca_engine;
  localparam int W = 8;
  localparam int G = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  ca_engine_if #(.WIDTH(W), .GEN_W(G)) bus ();

  ca_engine #(.WIDTH(W), .GEN_W(G)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int seq[$];

  typedef struct {
    logic [7:0] seed;
    logic [7:0] rule;
    bit         bz;
    logic [7:0] exp;
    bit         st;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Rule lookup on {left, centre, right}; left is index i+1, right is i-1.
  function automatic int mnext(input int s, input int r, input bit bz);
    int n, l, c, rr;
    n = 0;
    for (int i = 0; i < W; i++) begin
      c  = (s >> i) & 1;
      l  = (bz && i == W - 1) ? 0 : (s >> ((i + 1) % W)) & 1;
      rr = (bz && i == 0) ? 0 : (s >> ((i + W - 1) % W)) & 1;
      n  = n | (((r >> (l * 4 + c * 2 + rr)) & 1) << i);
    end
    return n;
  endfunction

  task automatic do_load(input int s);
    bus.seed = s[7:0];
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
  endtask

  task automatic do_step();
    bus.step = 1'b1;
    cyc();
    bus.step = 1'b0;
  endtask

  task automatic do_start(input int r, input bit bz, input int lim, input bit ss);
    bus.rule        = r[7:0];
    bus.bnd_zero    = bz;
    bus.gen_limit   = lim[G-1:0];
    bus.stop_stable = ss;
    bus.start       = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic run_wait(output int gens, output int dones);
    gens  = 0;
    dones = 0;
    seq.delete();
    for (int k = 0; k < 300; k++) begin
      cyc();
      gens++;
      seq.push_back(int'(bus.state));
      if (bus.done) dones++;
      if (!bus.busy) break;
    end
    if (bus.busy) chk("run_timeout", 1, 0);
    cyc();
    if (bus.done) dones++;
  endtask

  initial begin
    int gens, dones, ms, mg, mst, sd, rl, lim, k;
    bit bz, ss;

    tbl[0] = '{8'h80, 8'hAA, 1'b0, 8'h01, 1'b0};
    tbl[1] = '{8'h80, 8'hAA, 1'b1, 8'h00, 1'b0};
    tbl[2] = '{8'h01, 8'h5A, 1'b0, 8'h82, 1'b0};
    tbl[3] = '{8'h01, 8'h5A, 1'b1, 8'h02, 1'b0};
    tbl[4] = '{8'h5A, 8'hCC, 1'b0, 8'h5A, 1'b1};
    tbl[5] = '{8'h01, 8'hF0, 1'b0, 8'h80, 1'b0};
    tbl[6] = '{8'h01, 8'hF0, 1'b1, 8'h00, 1'b0};
    tbl[7] = '{8'hFF, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[8] = '{8'h00, 8'hFF, 1'b1, 8'hFF, 1'b0};

    bus.load = 0; bus.seed = 0; bus.rule = 0; bus.bnd_zero = 0;
    bus.step = 0; bus.start = 0; bus.gen_limit = 0;
    bus.stop_stable = 0; bus.halt = 0;

    #12;
    chk("rst_state", bus.state, 0);
    chk("rst_gen", bus.gen_count, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_stable", bus.stable, 0);
    @(negedge clk);
    resetn = 1'b1;
    cyc();

    foreach (tbl[i]) begin
      do_load(tbl[i].seed);
      bus.rule     = tbl[i].rule;
      bus.bnd_zero = tbl[i].bz;
      do_step();
      chk($sformatf("tbl%0d_state", i), bus.state, tbl[i].exp);
      chk($sformatf("tbl%0d_stable", i), bus.stable, tbl[i].st);
      chk($sformatf("tbl%0d_gen", i), bus.gen_count, 1);
    end

    do_load(8'h10);
    do_start(8'h5A, 1'b0, 4, 1'b0);
    chk("run4_busy", bus.busy, 1);
    chk("run4_gen0", bus.gen_count, 0);
    chk("run4_st0", bus.state, 8'h10);
    bus.rule = 8'h00;
    bus.bnd_zero = 1'b1;
    bus.gen_limit = 1;
    run_wait(gens, dones);
    chk("run4_gens", gens, 4);
    chk("run4_dones", dones, 1);
    if (seq.size() == 4) begin
      chk("run4_s1", seq[0], 8'h28);
      chk("run4_s2", seq[1], 8'h44);
      chk("run4_s3", seq[2], 8'hAA);
      chk("run4_s4", seq[3], 8'h00);
    end else chk("run4_len", seq.size(), 4);
    chk("run4_gen", bus.gen_count, 4);
    chk("run4_stable", bus.stable, 0);

    do_load(8'h10);
    do_start(8'h5A, 1'b0, 10, 1'b1);
    run_wait(gens, dones);
    chk("ss_gens", gens, 5);
    chk("ss_dones", dones, 1);
    chk("ss_gen", bus.gen_count, 5);
    chk("ss_stable", bus.stable, 1);
    chk("ss_state", bus.state, 0);

    do_load(8'h3C);
    do_start(8'h5A, 1'b0, 0, 1'b0);
    chk("zl_done", bus.done, 1);
    chk("zl_busy", bus.busy, 0);
    chk("zl_state", bus.state, 8'h3C);
    chk("zl_gen", bus.gen_count, 0);
    cyc();
    chk("zl_done2", bus.done, 0);
    chk("zl_busy2", bus.busy, 0);

    do_load(8'h10);
    do_start(8'h5A, 1'b0, 100, 1'b0);
    cyc(); cyc(); cyc();
    bus.halt = 1'b1;
    cyc();
    bus.halt = 1'b0;
    chk("halt_busy", bus.busy, 0);
    chk("halt_gen", bus.gen_count, 3);
    chk("halt_state", bus.state, 8'hAA);
    chk("halt_done", bus.done, 0);
    cyc();
    chk("halt_done2", bus.done, 0);
    chk("halt_hold", bus.state, 8'hAA);

    bus.seed = 8'h77;
    bus.gen_limit = 5;
    bus.load = 1'b1;
    bus.start = 1'b1;
    cyc();
    bus.load = 1'b0;
    bus.start = 1'b0;
    chk("ls_state", bus.state, 8'h77);
    chk("ls_busy", bus.busy, 0);
    cyc();
    chk("ls_busy2", bus.busy, 0);
    chk("ls_hold", bus.state, 8'h77);

    do_load(8'h10);
    do_start(8'h5A, 1'b0, 50, 1'b0);
    cyc(); cyc();
    #2 resetn = 1'b0;
    #1;
    chk("ar_state", bus.state, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_gen", bus.gen_count, 0);
    @(negedge clk);
    resetn = 1'b1;
    k = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (bus.done || bus.busy) k++;
    end
    chk("ar_quiet", k, 0);

    for (int it = 0; it < 24; it++) begin
      sd = $urandom_range(0, 255);
      rl = $urandom_range(0, 255);
      bz = 1'($urandom_range(0, 1));
      do_load(sd);
      if (it % 2 == 0) begin
        bus.rule = rl[7:0];
        bus.bnd_zero = bz;
        ms = sd;
        k = $urandom_range(1, 3);
        for (int j = 1; j <= k; j++) begin
          mg = mnext(ms, rl, bz);
          mst = (mg == ms);
          ms = mg;
          do_step();
          chk($sformatf("rs%0d_%0d_state", it, j), bus.state, ms);
          chk($sformatf("rs%0d_%0d_stab", it, j), bus.stable, mst);
          chk($sformatf("rs%0d_%0d_gen", it, j), bus.gen_count, j);
        end
      end else begin
        lim = $urandom_range(1, 12);
        ss  = 1'($urandom_range(0, 1));
        ms = sd; mg = 0; mst = 0;
        while (1) begin
          k = mnext(ms, rl, bz);
          mst = (k == ms);
          ms = k;
          mg++;
          if (mg == lim || (ss && mst)) break;
        end
        do_start(rl, bz, lim, ss);
        bus.rule = ~rl[7:0];
        bus.bnd_zero = ~bz;
        run_wait(gens, dones);
        chk($sformatf("rr%0d_state", it), bus.state, ms);
        chk($sformatf("rr%0d_gen", it), bus.gen_count, mg);
        chk($sformatf("rr%0d_stab", it), bus.stable, mst);
        chk($sformatf("rr%0d_gens", it), gens, mg);
        chk($sformatf("rr%0d_done", it), dones, 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
